// File: rtl/exe_mem_wb_pkg.sv
// rtl/exe_mem_wb_pkg.sv - shared types and default widths for the exe/mem-to-writeback stage
package exe_mem_wb_pkg;
  localparam int DATA_W_DEF = 10;
  localparam int ADDR_W_DEF = 3;
  localparam int CNT_W_DEF  = 8;

  // Encoding mirrors {main_valid, skid_valid} so the state is read straight off the entries.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } pipe_state_t;

  typedef struct packed {
    logic                  wb_en;
    logic [DATA_W_DEF-1:0] rdata;
    logic [ADDR_W_DEF-1:0] waddr;
  } wb_rec_t;
endpackage

// File: rtl/exe_mem_wb_pipe_if.sv
// rtl/exe_mem_wb_pipe_if.sv - upstream, writeback and forwarding signals of the stage
interface exe_mem_wb_pipe_if
  import exe_mem_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic              in_wb_en;
  logic [DATA_W-1:0] in_rdata;
  logic [ADDR_W-1:0] in_waddr;
  logic              out_valid;
  logic              out_ready;
  logic              out_wb_en;
  logic [DATA_W-1:0] out_rdata;
  logic [ADDR_W-1:0] out_waddr;
  logic [ADDR_W-1:0] fwd_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  modport master (
    output in_valid, in_wb_en, in_rdata, in_waddr, out_ready, fwd_addr,
    input  in_ready, out_valid, out_wb_en, out_rdata, out_waddr, fwd_hit, fwd_data
  );

  modport slave (
    input  in_valid, in_wb_en, in_rdata, in_waddr, out_ready, fwd_addr,
    output in_ready, out_valid, out_wb_en, out_rdata, out_waddr, fwd_hit, fwd_data
  );
endinterface

// File: rtl/wb_pipe_entry.sv
// rtl/wb_pipe_entry.sv - one held writeback record with its valid bit
module wb_pipe_entry #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] rec_in,
  output logic         valid,
  output logic [W-1:0] rec
);
  logic         valid_d, valid_q;
  logic [W-1:0] rec_d, rec_q;

  // Clear wins over load so a flush can never leave a freshly loaded entry valid.
  always_comb begin
    valid_d = valid_q;
    rec_d   = rec_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      rec_d   = rec_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      rec_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rec_q   <= rec_d;
    end
  end

  assign valid = valid_q;
  assign rec   = rec_q;
endmodule

// File: rtl/exe_mem_wb_pipe.sv
// rtl/exe_mem_wb_pipe.sv - two-entry skid-buffered writeback stage with flush and forwarding
module exe_mem_wb_pipe
  import exe_mem_wb_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter bit FWD_SKIP_R0 = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  exe_mem_wb_pipe_if.slave     bus,
  output logic [CNT_W-1:0]     flush_cnt
);
  localparam int REC_W = 1 + DATA_W + ADDR_W;

  logic              accept, consume;
  logic              main_valid, skid_valid;
  logic [REC_W-1:0]  main_rec, skid_rec, in_rec, main_in;
  logic              main_load, main_clr, skid_load, skid_clr, main_from_skid;
  logic              in_ready_d, in_ready_q;
  logic [CNT_W-1:0]  flush_cnt_d, flush_cnt_q;
  logic [1:0]        flushed;
  logic [CNT_W:0]    cnt_sum;
  logic              fwd_en, main_hit, skid_hit;
  pipe_state_t       state;

  assign in_rec  = {bus.in_wb_en, bus.in_rdata, bus.in_waddr};
  assign accept  = bus.in_valid & in_ready_q;
  assign consume = main_valid & bus.out_ready;
  assign state   = pipe_state_t'({main_valid, skid_valid});
  assign main_in = main_from_skid ? skid_rec : in_rec;

  always_comb begin
    main_load      = 1'b0;
    main_clr       = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state)
        EMPTY: main_load = accept;
        ONE: begin
          if (accept && consume) main_load = 1'b1;
          else if (accept)       skid_load = 1'b1;
          else if (consume)      main_clr  = 1'b1;
        end
        FULL: begin
          if (consume) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Ready looks only at the next skid occupancy, keeping out_ready off the in_ready path.
  assign in_ready_d = !((skid_valid & !skid_clr) | skid_load);

  // A record consumed in the flush cycle reached writeback, so it is not counted as discarded.
  assign flushed = {1'b0, main_valid} + {1'b0, skid_valid} + {1'b0, accept} - {1'b0, consume};
  assign cnt_sum = {1'b0, flush_cnt_q} + (CNT_W+1)'(flushed);

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (flush) flush_cnt_d = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_q  <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      in_ready_q  <= in_ready_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  wb_pipe_entry #(.W(REC_W)) u_main (
    .clk(clk), .reset(reset), .load(main_load), .clr(main_clr),
    .rec_in(main_in), .valid(main_valid), .rec(main_rec)
  );

  wb_pipe_entry #(.W(REC_W)) u_skid (
    .clk(clk), .reset(reset), .load(skid_load), .clr(skid_clr),
    .rec_in(in_rec), .valid(skid_valid), .rec(skid_rec)
  );

  assign fwd_en   = !(FWD_SKIP_R0 && (bus.fwd_addr == '0));
  assign main_hit = fwd_en & main_valid & main_rec[REC_W-1] & (main_rec[ADDR_W-1:0] == bus.fwd_addr);
  assign skid_hit = fwd_en & skid_valid & skid_rec[REC_W-1] & (skid_rec[ADDR_W-1:0] == bus.fwd_addr);

  always_comb begin
    bus.fwd_data = '0;
    if (skid_hit)      bus.fwd_data = skid_rec[ADDR_W +: DATA_W];
    else if (main_hit) bus.fwd_data = main_rec[ADDR_W +: DATA_W];
  end

  assign bus.fwd_hit   = main_hit | skid_hit;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_valid;
  assign bus.out_wb_en = main_valid & main_rec[REC_W-1];
  assign bus.out_rdata = main_rec[ADDR_W +: DATA_W];
  assign bus.out_waddr = main_rec[ADDR_W-1:0];
  assign flush_cnt     = flush_cnt_q;
endmodule

// File: tb/tb_exe_mem_wb_pipe.sv
// tb/tb_exe_mem_wb_pipe.sv - self-checking bench for exe_mem_wb_pipe against a queue model
module tb_exe_mem_wb_pipe;
  import exe_mem_wb_pkg::*;

  logic       clk = 1'b0;
  logic       reset, flush;
  logic [7:0] cnt_a_o;
  logic [1:0] cnt_b_o;

  always #5 clk = ~clk;

  exe_mem_wb_pipe_if #(.DATA_W(10), .ADDR_W(3)) bus_a ();
  exe_mem_wb_pipe_if #(.DATA_W(10), .ADDR_W(3)) bus_b ();

  exe_mem_wb_pipe #(.DATA_W(10), .ADDR_W(3), .CNT_W(8), .FWD_SKIP_R0(1'b0)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus_a), .flush_cnt(cnt_a_o)
  );
  exe_mem_wb_pipe #(.DATA_W(10), .ADDR_W(3), .CNT_W(2), .FWD_SKIP_R0(1'b1)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus_b), .flush_cnt(cnt_b_o)
  );

  wb_rec_t q[$];
  wb_rec_t shown;
  bit      m_rdy;
  int      m_cnt_a, m_cnt_b;
  int      n_cmp, n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_dut(input string n, input logic rdy, input logic ov, input logic wbe,
                           input logic [9:0] rd, input logic [2:0] wa, input logic hit,
                           input logic [9:0] fd, input logic [7:0] cnt, input bit skip,
                           input int mcnt, input logic [2:0] fa);
    logic       e_hit;
    logic [9:0] e_fd;
    e_hit = 1'b0;
    e_fd  = '0;
    if (!(skip && fa == 3'd0))
      foreach (q[i]) if (q[i].wb_en && q[i].waddr == fa) begin
        e_hit = 1'b1;
        e_fd  = q[i].rdata;
      end
    chk({n, ".in_ready"},  rdy, m_rdy);
    chk({n, ".out_valid"}, ov, q.size() > 0);
    chk({n, ".out_wb_en"}, wbe, (q.size() > 0) && shown.wb_en);
    chk({n, ".out_rdata"}, rd, shown.rdata);
    chk({n, ".out_waddr"}, wa, shown.waddr);
    chk({n, ".fwd_hit"},   hit, e_hit);
    chk({n, ".fwd_data"},  fd, e_fd);
    chk({n, ".flush_cnt"}, cnt, mcnt);
  endtask

  task automatic cyc(input bit rst, input bit fl, input bit iv, input bit wb,
                     input logic [9:0] rd, input logic [2:0] wa, input bit ordy,
                     input logic [2:0] fa);
    bit      acc, con;
    wb_rec_t r;
    reset = rst;
    flush = fl;
    bus_a.in_valid = iv; bus_a.in_wb_en = wb; bus_a.in_rdata = rd; bus_a.in_waddr = wa;
    bus_a.out_ready = ordy; bus_a.fwd_addr = fa;
    bus_b.in_valid = iv; bus_b.in_wb_en = wb; bus_b.in_rdata = rd; bus_b.in_waddr = wa;
    bus_b.out_ready = ordy; bus_b.fwd_addr = fa;
    #2;
    check_dut("a", bus_a.in_ready, bus_a.out_valid, bus_a.out_wb_en, bus_a.out_rdata,
              bus_a.out_waddr, bus_a.fwd_hit, bus_a.fwd_data, cnt_a_o, 1'b0, m_cnt_a, fa);
    check_dut("b", bus_b.in_ready, bus_b.out_valid, bus_b.out_wb_en, bus_b.out_rdata,
              bus_b.out_waddr, bus_b.fwd_hit, bus_b.fwd_data, {6'd0, cnt_b_o}, 1'b1, m_cnt_b, fa);
    r.wb_en = wb;
    r.rdata = rd;
    r.waddr = wa;
    acc = iv && m_rdy;
    con = (q.size() > 0) && ordy;
    if (rst) begin
      q.delete();
      m_rdy = 1'b0;
      m_cnt_a = 0;
      m_cnt_b = 0;
      shown = '0;
    end else if (fl) begin
      m_cnt_a = sat(m_cnt_a + q.size() + int'(acc) - int'(con), 255);
      m_cnt_b = sat(m_cnt_b + q.size() + int'(acc) - int'(con), 3);
      q.delete();
      m_rdy = 1'b1;
    end else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back(r);
      m_rdy = q.size() < 2;
    end
    if (q.size() > 0) shown = q[0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    m_rdy = 1'b0; m_cnt_a = 0; m_cnt_b = 0; shown = '0;
    reset = 1'b1; flush = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_wb_en = 1'b0; bus_a.in_rdata = '0; bus_a.in_waddr = '0;
    bus_a.out_ready = 1'b0; bus_a.fwd_addr = '0;
    bus_b.in_valid = 1'b0; bus_b.in_wb_en = 1'b0; bus_b.in_rdata = '0; bus_b.in_waddr = '0;
    bus_b.out_ready = 1'b0; bus_b.fwd_addr = '0;
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);

    for (int k = 1; k <= 5; k++) cyc(0, 0, 1, 1, 10'(k), 3'(k), 1, 3'(k));
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);

    cyc(0, 0, 1, 1, 10'h2AA, 1, 0, 1);
    cyc(0, 0, 1, 1, 10'h155, 2, 0, 2);
    cyc(0, 0, 1, 1, 10'h3FF, 3, 0, 3);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 2);
    cyc(0, 0, 0, 0, 0, 0, 1, 2);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);

    for (int n = 0; n < 3; n++) begin
      cyc(0, 0, 1, 1, 10'h010, 4, 0, 4);
      cyc(0, 0, 1, 1, 10'h020, 4, 0, 4);
      cyc(0, 0, 0, 0, 0, 0, 0, 4);
      cyc(0, 0, 0, 0, 0, 0, 0, 5);
      cyc(0, 1, 1, 1, 10'h3C3, 6, 0, 4);
      cyc(0, 0, 0, 0, 0, 0, 0, 4);
    end

    cyc(0, 0, 1, 1, 10'h0AB, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 10'h0CD, 6, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 6);
    cyc(0, 0, 0, 0, 0, 0, 1, 6);
    cyc(0, 0, 0, 0, 0, 0, 0, 6);
    cyc(0, 0, 0, 0, 0, 0, 1, 6);

    cyc(0, 0, 1, 1, 10'h111, 2, 0, 2);
    cyc(0, 0, 1, 1, 10'h222, 3, 0, 3);
    cyc(1, 1, 1, 1, 10'h333, 4, 0, 3);
    cyc(1, 1, 1, 1, 10'h333, 4, 0, 3);
    cyc(0, 0, 0, 0, 0, 0, 0, 3);
    cyc(0, 0, 1, 1, 10'h044, 5, 1, 5);
    cyc(0, 0, 0, 0, 0, 0, 1, 5);

    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 14) == 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 3) != 0, 10'($urandom), 3'($urandom), $urandom_range(0, 3) != 0,
          3'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
